// File: rtl/oai222_vector_checker_if.sv
// Stimulus/observation bundle between the OAI222 sweep engine and its host.
// The master drives start and the cell's ZN; the slave (checker) drives everything else.
interface oai222_vector_checker_if;
  logic       start;
  logic [5:0] vec_out;
  logic       zn_in;
  logic       busy;
  logic       obs_valid;
  logic [5:0] obs_vec;
  logic       obs_zn;
  logic       obs_err;
  logic       done;
  logic       pass;
  logic [6:0] err_count;
  logic       first_err_valid;
  logic [5:0] first_err_vec;

  modport master (
    output start, zn_in,
    input  vec_out, busy, obs_valid, obs_vec, obs_zn, obs_err, done, pass, err_count,
           first_err_valid, first_err_vec
  );

  modport slave (
    input  start, zn_in,
    output vec_out, busy, obs_valid, obs_vec, obs_zn, obs_err, done, pass, err_count,
           first_err_valid, first_err_vec
  );
endinterface

// File: rtl/oai222_vector_checker.sv
// Sweeps all 64 OAI222 input vectors in ascending order, samples ZN after SETTLE_CYC
// cycles and checks it against ~((A1|A2)&(B1|B2)&(C1|C2)).
module oai222_vector_checker #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input logic                    clk,
  input logic                    rst,
  oai222_vector_checker_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StFinish} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] vec_q, vec_d;
  logic       busy_q, busy_d;
  logic       obs_valid_q, obs_valid_d;
  logic [5:0] obs_vec_q, obs_vec_d;
  logic       obs_zn_q, obs_zn_d;
  logic       obs_err_q, obs_err_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [6:0] err_cnt_q, err_cnt_d;
  logic       fe_valid_q, fe_valid_d;
  logic [5:0] fe_vec_q, fe_vec_d;

  logic golden;
  logic mismatch;

  assign golden   = ~((vec_q[5] | vec_q[4]) & (vec_q[3] | vec_q[2]) & (vec_q[1] | vec_q[0]));
  // X/Z on zn_in propagates into obs_err unmasked.
  assign mismatch = bus.zn_in ^ golden;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    obs_valid_d = 1'b0;
    obs_vec_d   = obs_vec_q;
    obs_zn_d    = obs_zn_q;
    obs_err_d   = obs_err_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    fe_valid_d  = fe_valid_q;
    fe_vec_d    = fe_vec_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          err_cnt_d  = 7'd0;
          fe_valid_d = 1'b0;
          fe_vec_d   = 6'd0;
          pass_d     = 1'b0;
          vec_d      = 6'd0;
          busy_d     = 1'b1;
          cnt_d      = 4'd0;
          state_d    = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 4'(SETTLE_CYC - 1)) begin
          // Capture on the edge entering StSample so obs_* are presented during that cycle.
          state_d     = StSample;
          obs_valid_d = 1'b1;
          obs_vec_d   = vec_q;
          obs_zn_d    = bus.zn_in;
          obs_err_d   = mismatch;
          if (mismatch) begin
            err_cnt_d = err_cnt_q + 7'd1;
            if (!fe_valid_q) begin
              fe_valid_d = 1'b1;
              fe_vec_d   = vec_q;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        if (vec_q == 6'd63) begin
          state_d = StFinish;
          done_d  = 1'b1;
          pass_d  = (err_cnt_q == 7'd0);
          busy_d  = 1'b0;
        end else begin
          vec_d   = vec_q + 6'd1;
          cnt_d   = 4'd0;
          state_d = StSettle;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      vec_q       <= 6'd0;
      busy_q      <= 1'b0;
      obs_valid_q <= 1'b0;
      obs_vec_q   <= 6'd0;
      obs_zn_q    <= 1'b0;
      obs_err_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= 7'd0;
      fe_valid_q  <= 1'b0;
      fe_vec_q    <= 6'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      obs_valid_q <= obs_valid_d;
      obs_vec_q   <= obs_vec_d;
      obs_zn_q    <= obs_zn_d;
      obs_err_q   <= obs_err_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fe_valid_q  <= fe_valid_d;
      fe_vec_q    <= fe_vec_d;
    end
  end

  assign bus.vec_out         = vec_q;
  assign bus.busy            = busy_q;
  assign bus.obs_valid       = obs_valid_q;
  assign bus.obs_vec         = obs_vec_q;
  assign bus.obs_zn          = obs_zn_q;
  assign bus.obs_err         = obs_err_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_cnt_q;
  assign bus.first_err_valid = fe_valid_q;
  assign bus.first_err_vec   = fe_vec_q;

endmodule

// File: tb/tb_oai222_vector_checker.sv
// Scoreboard bench: three checkers (SETTLE_CYC = 1, 2, 3) each driven by a selectable cell model.
module tb_oai222_vector_checker;

  typedef struct {
    logic [5:0] vec;
    logic       zn;
    logic       err;
    int         cyc;
  } obs_t;

  typedef struct {
    int         cyc;
    int         errc;
    logic       fv;
    logic [5:0] fvec;
    logic       pass;
  } done_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;

  logic       start_a[3];
  int         mode_a[3];
  logic [5:0] prev_a[3];
  logic [5:0] vec_a[3];
  logic [5:0] ovec_a[3];
  logic [5:0] fvec_a[3];
  logic [6:0] errc_a[3];
  logic       busy_a[3];
  logic       valid_a[3];
  logic       ozn_a[3];
  logic       oerr_a[3];
  logic       done_a[3];
  logic       pass_a[3];
  logic       fev_a[3];
  int         obs_seen[3];
  int         done_seen[3];

  obs_t  exp_q[3][$];
  done_t done_q[3][$];

  function automatic logic gold(logic [5:0] v);
    return ~((v[5] | v[4]) & (v[3] | v[2]) & (v[1] | v[0]));
  endfunction

  // Modes: 0 good cell, 1 stuck-0, 2 stuck-1, 3 inverted, 4 output delayed two cycles.
  function automatic logic cell_zn(int md, logic g, logic dly);
    case (md)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~g;
      4:       return dly;
      default: return g;
    endcase
  endfunction

  // What the checker should observe for vector i of a sweep.
  function automatic logic model_zn(int md, int s, int i, logic [5:0] prev);
    logic [5:0] v;
    logic [5:0] pv;
    v  = 6'(i);
    pv = (i == 0) ? prev : 6'(i - 1);
    case (md)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~gold(v);
      4:       return (s >= 3) ? gold(v) : gold(pv);
      default: return gold(v);
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    oai222_vector_checker_if bus ();
    logic d1, d2;

    oai222_vector_checker #(.SETTLE_CYC(k + 1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    always @(posedge clk) begin
      d1 <= gold(bus.vec_out);
      d2 <= d1;
    end

    assign bus.start  = start_a[k];
    assign bus.zn_in  = cell_zn(mode_a[k], gold(bus.vec_out), d2);
    assign vec_a[k]   = bus.vec_out;
    assign busy_a[k]  = bus.busy;
    assign valid_a[k] = bus.obs_valid;
    assign ovec_a[k]  = bus.obs_vec;
    assign ozn_a[k]   = bus.obs_zn;
    assign oerr_a[k]  = bus.obs_err;
    assign done_a[k]  = bus.done;
    assign pass_a[k]  = bus.pass;
    assign errc_a[k]  = bus.err_count;
    assign fev_a[k]   = bus.first_err_valid;
    assign fvec_a[k]  = bus.first_err_vec;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset(int k);
    chk("rst_vec_out", 32'(vec_a[k]), 0);
    chk("rst_busy", 32'(busy_a[k]), 0);
    chk("rst_obs_valid", 32'(valid_a[k]), 0);
    chk("rst_obs_vec", 32'(ovec_a[k]), 0);
    chk("rst_obs_zn", 32'(ozn_a[k]), 0);
    chk("rst_obs_err", 32'(oerr_a[k]), 0);
    chk("rst_done", 32'(done_a[k]), 0);
    chk("rst_pass", 32'(pass_a[k]), 0);
    chk("rst_err_count", 32'(errc_a[k]), 0);
    chk("rst_first_err_valid", 32'(fev_a[k]), 0);
    chk("rst_first_err_vec", 32'(fvec_a[k]), 0);
  endtask

  task automatic monitor();
    obs_t  e;
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 3; k++) begin
          if (valid_a[k]) begin
            obs_seen[k]++;
            if (exp_q[k].size() == 0) begin
              chk("obs_unexpected", 32'(valid_a[k]), 0);
            end else begin
              e = exp_q[k].pop_front();
              chk("obs_vec", 32'(ovec_a[k]), 32'(e.vec));
              chk("obs_zn", 32'(ozn_a[k]), 32'(e.zn));
              chk("obs_err", 32'(oerr_a[k]), 32'(e.err));
              chk("obs_cycle", cyc, e.cyc);
            end
          end
          if (done_a[k]) begin
            done_seen[k]++;
            if (done_q[k].size() == 0) begin
              chk("done_unexpected", 32'(done_a[k]), 0);
            end else begin
              d = done_q[k].pop_front();
              chk("done_cycle", cyc, d.cyc);
              chk("err_count", 32'(errc_a[k]), d.errc);
              chk("first_err_valid", 32'(fev_a[k]), 32'(d.fv));
              chk("first_err_vec", 32'(fvec_a[k]), 32'(d.fvec));
              chk("pass", 32'(pass_a[k]), 32'(d.pass));
              chk("busy_at_done", 32'(busy_a[k]), 0);
            end
          end
        end
      end
    end
  endtask

  // Expected mismatch count / first failing vector for a given cell model.
  function automatic int model_errs(int md, int s, logic [5:0] prev, output logic [5:0] fv);
    int n;
    n  = 0;
    fv = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (model_zn(md, s, i, prev) !== gold(6'(i))) begin
        n++;
        fv = 6'(i);
      end
    end
    return n;
  endfunction

  // Queue the expected sweep, then pulse start in an IDLE cycle.
  task automatic issue(int k, int md, int errc, logic [5:0] fvec);
    int   s;
    int   e0;
    obs_t o;
    @(negedge clk);
    s  = k + 1;
    e0 = cyc + 1;
    for (int i = 0; i < 64; i++) begin
      o.vec = 6'(i);
      o.zn  = model_zn(md, s, i, prev_a[k]);
      o.err = o.zn ^ gold(6'(i));
      o.cyc = e0 + i * (s + 1) + s;
      exp_q[k].push_back(o);
    end
    done_q[k].push_back('{cyc: e0 + 64 * (s + 1), errc: errc, fv: (errc != 0), fvec: fvec,
                          pass: (errc == 0)});
    mode_a[k]  = md;
    start_a[k] = 1'b1;
    @(negedge clk);
    start_a[k] = 1'b0;
    chk("busy_after_start", 32'(busy_a[k]), 1);
    prev_a[k] = 6'd63;
  endtask

  task automatic wait_done(int k, bit start_on_done);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 64 * (k + 2) + 20; n++) begin
      @(negedge clk);
      if (done_a[k]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 1);
    if (seen && start_on_done) begin
      start_a[k] = 1'b1;
      @(negedge clk);
      start_a[k] = 1'b0;
      @(negedge clk);
      chk("finish_start_ignored", 32'(busy_a[k]), 0);
    end
  endtask

  initial begin
    int         e0;
    int         s0;
    int         d0;
    int         ne;
    logic [5:0] fv;

    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_a[k]   = 1'b0;
      mode_a[k]    = 0;
      prev_a[k]    = 6'd0;
      obs_seen[k]  = 0;
      done_seen[k] = 0;
    end
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_reset(k);
    rst = 1'b0;

    issue(1, 0, 0, 6'h00);
    wait_done(1, 1'b0);
    issue(1, 1, 37, 6'h00);
    wait_done(1, 1'b0);
    issue(1, 2, 27, 6'h15);
    wait_done(1, 1'b0);
    issue(0, 3, 64, 6'h00);
    wait_done(0, 1'b0);
    ne = model_errs(4, 1, prev_a[0], fv);
    issue(0, 4, ne, fv);
    wait_done(0, 1'b0);
    issue(2, 4, 0, 6'h00);
    wait_done(2, 1'b0);
    issue(2, 0, 0, 6'h00);
    wait_done(2, 1'b1);

    // Abort mid-sweep: reset lands on edge E0+50.
    issue(1, 0, 0, 6'h00);
    e0 = cyc;
    while (cyc < e0 + 49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset(1);
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      done_q[k].delete();
      prev_a[k] = 6'd0;
    end
    rst = 1'b0;
    repeat (250) @(negedge clk);

    // Fresh run with a redundant start while busy.
    s0 = obs_seen[1];
    d0 = done_seen[1];
    issue(1, 0, 0, 6'h00);
    repeat (20) @(negedge clk);
    start_a[1] = 1'b1;
    @(negedge clk);
    start_a[1] = 1'b0;
    wait_done(1, 1'b0);
    repeat (10) @(negedge clk);
    chk("fresh_obs_count", obs_seen[1] - s0, 64);
    chk("fresh_done_count", done_seen[1] - d0, 1);
    for (int k = 0; k < 3; k++) begin
      chk("obs_queue_empty", exp_q[k].size(), 0);
      chk("done_queue_empty", done_q[k].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
